scan_multiplexer: RTL
=====================

Name: scan_multiplexer

Overview:
Parametrised, registered N-channel multiplexer, the successor to the combinational 4:1 mux. It selects one WIDTH-bit channel from a flattened input bus. The channel comes either from an external select (manual mode) or from an internal auto-scan sequencer that dwells a fixed number of cycles on each channel. The block sits between multi-channel sources (sensor/data lines) and a single-lane consumer, and provides the current channel index, a valid strobe and a wrap pulse for framing.

Parameters:
WIDTH, 1, bit width of each channel.
CHANNELS, 4, number of input channels (>= 2, need not be a power of 2).
DWELL, 10, clock cycles spent on each channel in scan mode (>= 1).
SEL_W, $clog2(CHANNELS), select/index width; derived, not overridden.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  enable; when low, all state holds.
mode  input  1  0 = manual (use sel), 1 = auto-scan.
sel  input  SEL_W  manual channel select.
I  input  CHANNELS*WIDTH  flattened channels; channel k is I[k*WIDTH +: WIDTH].
Y  output  WIDTH  registered selected channel data.
ch  output  SEL_W  channel index currently driving Y.
valid  output  1  Y/ch were updated on the last edge (registered copy of en).
wrap  output  1  one-cycle pulse when the scan index wraps from CHANNELS-1 to 0.
err  output  1  registered flag: last manual sel was out of range.

Behaviour:
- Reset: one clock, synchronous, active-high. At the edge where rst=1: Y=0, ch=0, valid=0, wrap=0, err=0, dwell counter cnt=0. Reset overrides en, mode and all other inputs, including in the middle of a scan.
- Interface timing and latency:
  - All outputs are registered. On each edge with en=1, compute ch_next, then load ch<=ch_next and Y<=I[ch_next] in the same edge.
  - Y and ch are therefore always consistent. Latency from the I/sel inputs to Y is 1 cycle.
  - With en=1 and I changing while ch is fixed, Y tracks I[ch] with 1-cycle lag.
- en=0: Y, ch, cnt and err hold. valid<=0 and wrap<=0.
- Manual mode (mode=0, en=1):
  - If sel < CHANNELS: ch_next=sel and err<=0.
  - Otherwise: ch_next=ch (hold), Y is reloaded from I[ch], and err<=1.
  - cnt<=0. wrap<=0.
- Scan mode (mode=1, en=1):
  - If cnt==DWELL-1: cnt<=0 and ch_next=(ch==CHANNELS-1)?0:ch+1.
  - Otherwise: cnt<=cnt+1 and ch_next=ch.
  - wrap<=1 only on the edge where ch goes from CHANNELS-1 to 0; otherwise wrap<=0.
  - err<=0. sel is ignored.
- Dwell timing:
  - Every channel is presented for exactly DWELL consecutive enabled cycles.
  - DWELL=1 advances the channel every enabled cycle.
  - After reset, channel 0 is held for DWELL enabled cycles.
- Mode changes:
  - Manual to scan: scanning starts from the current ch with cnt=0 (cnt was already cleared in manual mode).
  - Scan to manual: ch takes a valid sel at the next edge, and the dwell progress is discarded.
- en deassertion mid-dwell: cnt is frozen and resumes on re-enable. The total enabled dwell per channel stays DWELL.
- Non-power-of-2 CHANNELS: the scan index never exceeds CHANNELS-1. Manual out-of-range handling is as above.
- valid<=en on every non-reset edge.

Test Plan:
1. Reset: assert rst for 2 cycles with en=1, mode=1 and I all ones -> Y=0, ch=0, valid=0, wrap=0, err=0.
2. Manual, CHANNELS=4, WIDTH=1: set I=4'b1010, step sel 0..3 with 10 cycles each -> one cycle after each change Y = 0,1,0,1 and ch = sel, valid=1, err=0.
3. Scan, CHANNELS=4, WIDTH=8, DWELL=3: set I={8'hDD,8'hCC,8'hBB,8'hAA} and run 14 cycles -> ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0,0 with Y following AA..DD; wrap high only on the first ch=0 cycle after ch=3.
4. Enable stall: in scan with DWELL=3, drop en for 4 cycles after the 2nd cycle on ch=1 -> Y and ch hold and valid=0 during the stall; after re-enable, ch=1 lasts 1 more enabled cycle and then goes to 2.
5. Out-of-range, CHANNELS=5 (SEL_W=3): manual sel=2, then sel=6 -> ch stays 2, err=1 one cycle later; then sel=4 -> ch=4, err=0.
6. Reset mid-scan: pulse rst while ch=2 and cnt=1, then keep mode=1 -> ch=0 and Y=0 at the reset edge, then Y=I[0] and channel 0 is held for a full DWELL cycles.

Source files
------------

// File: rtl/scan_multiplexer_if.sv
// Channel bus between a multi-channel source and the scan multiplexer:
// flattened channel inputs, select controls, and the registered selection outputs.
interface scan_multiplexer_if #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic                      en;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] I;
    logic [WIDTH-1:0]          Y;
    logic [SEL_W-1:0]          ch;
    logic                      valid;
    logic                      wrap;
    logic                      err;

    modport master (
        output en, mode, sel, I,
        input  Y, ch, valid, wrap, err
    );

    modport slave (
        input  en, mode, sel, I,
        output Y, ch, valid, wrap, err
    );
endinterface

// File: rtl/scan_multiplexer.sv
// Registered N-channel multiplexer with a manual select and an auto-scan
// sequencer that dwells a fixed number of enabled cycles on each channel.
// Y and ch are loaded on the same edge, so the data always matches the index.
module scan_multiplexer #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 10
) (
    input logic           clk,
    input logic           rst,
    scan_multiplexer_if.slave bus
);
    localparam int SEL_W = $clog2(CHANNELS);
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    // Channel count widened by one bit so an all-ones sel can be compared against it.
    localparam logic [SEL_W:0]   NUM_CH   = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [SEL_W-1:0] ch_next;
    logic [WIDTH-1:0] y_next;
    logic             err_next;
    logic             wrap_next;

    // Choose the next channel: manual select with range check, or dwell-based scan advance.
    always_comb begin
        ch_next   = bus.ch;
        cnt_next  = cnt;
        err_next  = bus.err;
        wrap_next = 1'b0;
        if (bus.mode) begin
            err_next = 1'b0;
            if (cnt == LAST_CNT) begin
                cnt_next = '0;
                if (bus.ch == LAST_CH) begin
                    ch_next   = '0;
                    wrap_next = 1'b1;
                end else begin
                    ch_next = bus.ch + 1'b1;
                end
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end else begin
            cnt_next = '0;
            if ({1'b0, bus.sel} < NUM_CH) begin
                ch_next  = bus.sel;
                err_next = 1'b0;
            end else begin
                err_next = 1'b1;
            end
        end
    end

    // Pick the data of the channel that will be presented after this edge.
    always_comb begin
        y_next = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch_next == SEL_W'(k)) begin
                y_next = bus.I[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output and dwell-counter registers; en low freezes everything except the strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.Y     <= '0;
            bus.ch    <= '0;
            bus.valid <= 1'b0;
            bus.wrap  <= 1'b0;
            bus.err   <= 1'b0;
            cnt       <= '0;
        end else begin
            bus.valid <= bus.en;
            if (bus.en) begin
                bus.Y    <= y_next;
                bus.ch   <= ch_next;
                bus.err  <= err_next;
                bus.wrap <= wrap_next;
                cnt      <= cnt_next;
            end else begin
                bus.wrap <= 1'b0;
            end
        end
    end
endmodule
